// File: rtl/gray_dir_decoder_pkg.sv
// Shared definitions for the Gray-code direction decoder.
// Holds the tracker state enum, the code width, the FAULT recovery length
// and the direction encoding used on output P.
package gray_dir_decoder_pkg;

    localparam int unsigned CODE_WIDTH = 3;

    // Consecutive unchanged samples needed in FAULT before resynchronising.
    localparam int unsigned FAULT_STABLE_CYCLES = 2;
    localparam int unsigned STABLE_W = $clog2(FAULT_STABLE_CYCLES + 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(FAULT_STABLE_CYCLES - 1);

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Index deltas (mod 2^CODE_WIDTH) that count as one legal move.
    localparam logic [CODE_WIDTH-1:0] DELTA_UP   = CODE_WIDTH'(1);
    localparam logic [CODE_WIDTH-1:0] DELTA_DOWN = '1;

    typedef enum logic [1:0] {
        SYNC,
        TRACK,
        FAULT
    } state_e;

endpackage

// File: rtl/gray_dir_decoder_gray3_to_bin.sv
// Combinational Gray-to-binary converter for the 3-bit position code.
// Ports:
//   gray_i : Gray code {Y2,Y1,Y0}
//   bin_o  : binary position index 0..7
module gray3_to_bin
    import gray_dir_decoder_pkg::*;
(
    input  logic [CODE_WIDTH-1:0] gray_i,
    output logic [CODE_WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_o[2] = gray_i[2];
        bin_o[1] = gray_i[2] ^ gray_i[1];
        bin_o[0] = gray_i[2] ^ gray_i[1] ^ gray_i[0];
    end

endmodule

// File: rtl/gray_dir_decoder.sv
// Recovers direction of travel from a 3-bit Gray-coded position and flags
// illegal jumps. The code is registered, converted to a binary index and
// compared with the previous index; a +1/-1 change (mod 8) is a step.
// Optional feature: define POSITION_COUNT_EN to add the 8-bit pos counter.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   Y0, Y1, Y2  : Gray code input (Y0 = LSB)
//   P           : direction of last step (0 up, 1 down)
//   step        : one-cycle pulse per legal single-position move
//   locked      : high while tracking
//   err         : high while in FAULT
//   pos         : wrapping position count (POSITION_COUNT_EN only)
module gray_dir_decoder
    import gray_dir_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       Y0,
    input  logic       Y1,
    input  logic       Y2,
    output logic       P,
    output logic       step,
    output logic       locked,
`ifdef POSITION_COUNT_EN
    output logic       err,
    output logic [7:0] pos
`else
    output logic       err
`endif
);

    logic [CODE_WIDTH-1:0] y_q, y_d;
    logic [CODE_WIDTH-1:0] b, b_prev_q, diff;
    state_e                state_q, state_d;
    logic                  p_q, p_d;
    logic                  step_q, step_d;
    logic                  locked_q, locked_d;
    logic                  err_q, err_d;
    logic                  sync_loaded_q, sync_loaded_d;
    logic [STABLE_W-1:0]   stable_q, stable_d;

    gray3_to_bin u_gray3_to_bin (
        .gray_i (y_q),
        .bin_o  (b)
    );

    assign y_d  = {Y2, Y1, Y0};
    // 3-bit subtraction wraps naturally, so 7->0 gives +1 and 0->7 gives -1.
    assign diff = b - b_prev_q;

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        step_d        = 1'b0;
        stable_d      = stable_q;
        sync_loaded_d = sync_loaded_q;
        unique case (state_q)
            SYNC: begin
                // First edge only establishes b_prev; the next one locks.
                if (!sync_loaded_q) begin
                    sync_loaded_d = 1'b1;
                end else begin
                    sync_loaded_d = 1'b0;
                    state_d       = TRACK;
                end
            end
            TRACK: begin
                if (diff == DELTA_UP) begin
                    step_d = 1'b1;
                    p_d    = DIR_UP;
                end else if (diff == DELTA_DOWN) begin
                    step_d = 1'b1;
                    p_d    = DIR_DOWN;
                end else if (diff != '0) begin
                    state_d  = FAULT;
                    stable_d = '0;
                end
            end
            FAULT: begin
                // diff == 0 means y_q did not change across the last edge.
                if (diff == '0) begin
                    if (stable_q == STABLE_LAST) begin
                        state_d       = SYNC;
                        stable_d      = '0;
                        sync_loaded_d = 1'b0;
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end else begin
                    stable_d = '0;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
        locked_d = (state_d == TRACK);
        err_d    = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q           <= '0;
            b_prev_q      <= '0;
            state_q       <= SYNC;
            p_q           <= DIR_UP;
            step_q        <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            sync_loaded_q <= 1'b0;
            stable_q      <= '0;
        end else begin
            y_q           <= y_d;
            b_prev_q      <= b;
            state_q       <= state_d;
            p_q           <= p_d;
            step_q        <= step_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            sync_loaded_q <= sync_loaded_d;
            stable_q      <= stable_d;
        end
    end

    assign P      = p_q;
    assign step   = step_q;
    assign locked = locked_q;
    assign err    = err_q;

`ifdef POSITION_COUNT_EN
    logic [7:0] pos_q, pos_d;

    // step_d is only ever set in TRACK, so pos holds in SYNC and FAULT.
    always_comb begin
        pos_d = pos_q;
        if (step_d) begin
            pos_d = (p_d == DIR_DOWN) ? pos_q - 8'd1 : pos_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;
`endif

endmodule

// File: tb/tb_gray_dir_decoder.sv
// Self-checking bench for gray_dir_decoder: directed scenarios plus a
// randomized walk, all compared against a behavioural model that works on
// position indices looked up from the Gray order table.
module tb_gray_dir_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Y0 = 1'b0;
    logic       Y1 = 1'b0;
    logic       Y2 = 1'b0;
    logic       P, step, locked, err;
`ifdef POSITION_COUNT_EN
    logic [7:0] pos;
`endif

    gray_dir_decoder dut (
        .clk    (clk),
        .reset  (reset),
        .Y0     (Y0),
        .Y1     (Y1),
        .Y2     (Y2),
        .P      (P),
        .step   (step),
        .locked (locked),
`ifdef POSITION_COUNT_EN
        .err    (err),
        .pos    (pos)
`else
        .err    (err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Gray code sequence: gray_order[i] is the code at position i.
    int gray_order[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    localparam int M_SYNC  = 0;
    localparam int M_TRACK = 1;
    localparam int M_FAULT = 2;

    int m_state = M_SYNC, m_yi = 0, m_prev = 0, m_stable = 0, m_pos = 0;
    bit m_phase = 0, m_p = 0, m_step = 0;

    function automatic int gray_idx(input logic [2:0] g);
        int r = 0;
        for (int i = 0; i < 8; i++) if (gray_order[i] == int'(g)) r = i;
        return r;
    endfunction

    function automatic logic [2:0] code_at(input int i);
        return 3'(gray_order[((i % 8) + 8) % 8]);
    endfunction

    // One clock edge of the reference behaviour.
    function automatic void model_edge(input logic [2:0] g, input bit r);
        int d;
        if (r) begin
            m_state = M_SYNC; m_yi = 0; m_prev = 0; m_stable = 0; m_pos = 0;
            m_phase = 0; m_p = 0; m_step = 0;
            return;
        end
        d = (m_yi - m_prev + 8) % 8;
        m_step = 0;
        case (m_state)
            M_SYNC: begin
                if (!m_phase) m_phase = 1;
                else begin m_phase = 0; m_state = M_TRACK; end
            end
            M_TRACK: begin
                if (d == 1) begin m_step = 1; m_p = 0; m_pos = (m_pos + 1) % 256; end
                else if (d == 7) begin m_step = 1; m_p = 1; m_pos = (m_pos + 255) % 256; end
                else if (d != 0) begin m_state = M_FAULT; m_stable = 0; end
            end
            default: begin
                if (d == 0) begin
                    m_stable++;
                    if (m_stable >= 2) begin m_state = M_SYNC; m_stable = 0; m_phase = 0; end
                end else m_stable = 0;
            end
        endcase
        m_prev = m_yi;
        m_yi   = gray_idx(g);
    endfunction

    function automatic logic [11:0] exp_vec();
        return {m_p, m_step, m_state == M_TRACK, m_state == M_FAULT,
`ifdef POSITION_COUNT_EN
                8'(m_pos)};
`else
                8'h00};
`endif
    endfunction

    function automatic logic [11:0] got_vec();
`ifdef POSITION_COUNT_EN
        return {P, step, locked, err, pos};
`else
        return {P, step, locked, err, 8'h00};
`endif
    endfunction

    // Drive one sample, clock it, advance the model, settle past the edge.
    task automatic tick(input logic [2:0] g, input bit r);
        {Y2, Y1, Y0} = g;
        reset = r;
        @(posedge clk);
        model_edge(g, r);
        #1;
    endtask

    task automatic resync(input logic [2:0] g);
        tick(3'b000, 1'b1);
        repeat (3) tick(g, 1'b0);
    endtask

    task automatic test_reset();
        tick(3'b101, 1'b1);
        tick(3'b101, 1'b1);
        if ({P, step, locked, err} !== 4'b0000) begin
            n_err++; $display("FAIL reset_outs: got %b exp 0000", {P, step, locked, err});
        end
        n_chk++;
`ifdef POSITION_COUNT_EN
        if (pos !== 8'd0) begin n_err++; $display("FAIL reset_pos: got %0d exp 0", pos); end
        n_chk++;
`endif
        for (int i = 0; i < 3; i++) begin
            tick(3'b000, 1'b0);
            if ({step, locked, err} !== {1'b0, i >= 1, 1'b0}) begin
                n_err++;
                $display("FAIL reset_lock[%0d]: got %b exp %b", i, {step, locked, err},
                         {1'b0, i >= 1, 1'b0});
            end
            n_chk++;
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL reset_model: got %h exp %h", got_vec(), exp_vec());
            end
            n_chk++;
        end
    endtask

    task automatic test_up();
        int steps = 0;
        logic [2:0] seq[5] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b010};
        resync(3'b000);
        foreach (seq[i]) begin
            tick(seq[i], 1'b0);
            steps += int'(step);
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL up_model: got %h exp %h", got_vec(), exp_vec());
            end
            n_chk++;
        end
        if (steps != 3 || P !== 1'b0) begin
            n_err++; $display("FAIL up_steps: got %0d/P=%b exp 3/P=0", steps, P);
        end
        n_chk++;
`ifdef POSITION_COUNT_EN
        if (pos !== 8'd3) begin n_err++; $display("FAIL up_pos: got %0d exp 3", pos); end
        n_chk++;
`endif
    endtask

    task automatic test_down_wrap();
        int steps = 0;
        logic [2:0] seq[3] = '{3'b100, 3'b101, 3'b101};
        resync(3'b000);
        foreach (seq[i]) begin
            tick(seq[i], 1'b0);
            steps += int'(step);
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL down_model: got %h exp %h", got_vec(), exp_vec());
            end
            n_chk++;
        end
        if (steps != 2 || P !== 1'b1) begin
            n_err++; $display("FAIL down_steps: got %0d/P=%b exp 2/P=1", steps, P);
        end
        n_chk++;
`ifdef POSITION_COUNT_EN
        if (pos !== 8'd254) begin n_err++; $display("FAIL down_pos: got %0d exp 254", pos); end
        n_chk++;
`endif
    endtask

    task automatic test_fault();
        resync(3'b000);
        tick(3'b001, 1'b0);
        tick(3'b001, 1'b0);
        tick(3'b110, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick(3'b110, 1'b0);
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL fault_model[%0d]: got %h exp %h", i, got_vec(), exp_vec());
            end
            n_chk++;
            if (i == 1 && {err, locked} !== 2'b10) begin
                n_err++; $display("FAIL fault_enter: got err,locked=%b exp 10", {err, locked});
            end
            if (i == 5 && {err, locked} !== 2'b01) begin
                n_err++; $display("FAIL fault_relock: got err,locked=%b exp 01", {err, locked});
            end
            if (i == 1 || i == 5) n_chk++;
        end
    endtask

    task automatic test_reset_in_fault();
        int budget = 10;
        logic [2:0] seq[8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b111, 3'b000};
        resync(3'b000);
        foreach (seq[i]) tick(seq[i], 1'b0);
        while (!err && budget > 0) begin tick(3'b000, 1'b0); budget--; end
        if (got_vec() !== exp_vec() || err !== 1'b1) begin
            n_err++; $display("FAIL rif_pre: got %h exp %h", got_vec(), exp_vec());
        end
        n_chk++;
`ifdef POSITION_COUNT_EN
        if (pos !== 8'd5) begin n_err++; $display("FAIL rif_pos5: got %0d exp 5", pos); end
        n_chk++;
`endif
        tick(3'b000, 1'b1);
        if ({P, step, locked, err} !== 4'b0000) begin
            n_err++; $display("FAIL rif_reset: got %b exp 0000", {P, step, locked, err});
        end
        n_chk++;
`ifdef POSITION_COUNT_EN
        if (pos !== 8'd0) begin n_err++; $display("FAIL rif_pos0: got %0d exp 0", pos); end
        n_chk++;
`endif
    endtask

    task automatic test_reversal();
        resync(3'b011);
        tick(3'b001, 1'b0);
        tick(3'b011, 1'b0);
        if ({step, P} !== 2'b11) begin
            n_err++; $display("FAIL rev_down: got step,P=%b exp 11", {step, P});
        end
        n_chk++;
        tick(3'b011, 1'b0);
        if ({step, P} !== 2'b10) begin
            n_err++; $display("FAIL rev_up: got step,P=%b exp 10", {step, P});
        end
        n_chk++;
        if (got_vec() !== exp_vec()) begin
            n_err++; $display("FAIL rev_model: got %h exp %h", got_vec(), exp_vec());
        end
        n_chk++;
    endtask

    task automatic test_random();
        int ci = 0;
        int sel;
        bit r;
        resync(3'b000);
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 99));
            r = 1'b0;
            if (sel < 40) ci++;
            else if (sel < 80) ci--;
            else if (sel < 92) ci = ci;
            else if (sel < 98) ci = int'($urandom_range(0, 7));
            else r = 1'b1;
            tick(code_at(ci), r);
            if (got_vec() !== exp_vec()) begin
                n_err++; $display("FAIL rand[%0d]: got %h exp %h", n, got_vec(), exp_vec());
            end
            n_chk++;
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down_wrap();
        test_fault();
        test_reset_in_fault();
        test_reversal();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gray_dir_decoder.md
GRAY_DIR_DECODER -- requirements
Module: gray_dir_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port Y0, input, 1 bit: Gray code bit 0 (LSB) from the 3-bit Gray counter FSM.
REQ-005 Port Y1, input, 1 bit: Gray code bit 1.
REQ-006 Port Y2, input, 1 bit: Gray code bit 2 (MSB).
REQ-007 Port P, output, 1 bit: recovered direction; 0 means up, 1 means down.
REQ-008 Port step, output, 1 bit: one-cycle pulse per legal single-position move.
REQ-009 Port locked, output, 1 bit: 1 while in TRACK.
REQ-010 Port err, output, 1 bit: 1 while in FAULT.
REQ-011 Port pos, output, 8 bits: position count; present only with POSITION_COUNT_EN.

Function
REQ-012 Gray order SHALL be 000,001,011,010,110,111,101,100 (Y2Y1Y0), with binary index 0..7, wrapping 7->0.
REQ-013 {Y2,Y1,Y0} SHALL be registered into y_q each edge; y_q SHALL be converted to a binary index b, and the previous index b_prev SHALL be kept.
REQ-014 d = (b - b_prev) mod 8, computed in 3-bit wrap arithmetic.
REQ-015 States SHALL be SYNC, TRACK and FAULT; state, P, step, locked, err and pos are all registered.
REQ-016 SYNC: the first edge after reset loads b_prev; the next edge moves to TRACK with no step.
REQ-017 TRACK, d=0: hold; step=0; P unchanged.
REQ-018 TRACK, d=1: step=1 for one cycle; P=0.
REQ-019 TRACK, d=7: step=1 for one cycle; P=1.
REQ-020 TRACK, d in 2..6: go to FAULT; step=0; P unchanged.
REQ-021 FAULT: err=1 and locked=0; return to SYNC after y_q is unchanged for 2 consecutive edges.
REQ-022 Latency: a code change present before edge N SHALL produce step/P/err at edge N+1.
REQ-023 Wrap: 100->000 SHALL be an up step, and 000->100 a down step.
REQ-024 A direction reversal on consecutive samples SHALL be legal; P SHALL follow each step.
REQ-025 Input change every cycle SHALL be tracked with no missed steps.

Reset
REQ-026 Reset SHALL override all other conditions, including mid-step and in FAULT.
REQ-027 Reset values: state=SYNC, P=0, step=0, locked=0, err=0, pos=0, y_q=000, b_prev=0, stable counter=0.

Configuration
REQ-028 Macro POSITION_COUNT_EN SHALL control the position counter.
REQ-029 With POSITION_COUNT_EN defined, pos SHALL increment on an up step and decrement on a down step, wrapping 255<->0.
REQ-030 With POSITION_COUNT_EN defined, pos SHALL hold in SYNC and FAULT.
REQ-031 Without POSITION_COUNT_EN, the pos port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-032 A shared package SHALL hold the state enum (SYNC/TRACK/FAULT), the 3-bit code width, FAULT_STABLE_CYCLES=2, and DIR_UP=0/DIR_DOWN=1.
REQ-033 Sub-module gray3_to_bin SHALL be a combinational 3-bit Gray-to-binary converter instantiated once.

Verification
REQ-034 Reset, hold 000 for 3 cycles -> locked=1 from the 2nd post-reset edge; step=0; err=0.
REQ-035 Drive 000,001,011,010 on successive cycles -> 3 step pulses; P=0; pos=3 with POSITION_COUNT_EN.
REQ-036 From 000, drive 100 then 101 -> 2 steps; P=1; pos=254 with POSITION_COUNT_EN.
REQ-037 In TRACK at 001, jump to 110 -> err=1 and locked=0 at the next edge; hold 110 for 2 cycles -> SYNC, then TRACK, err=0.
REQ-038 Assert reset while in FAULT with pos=5 -> the next edge gives err=0, state=SYNC, pos=0, P=0.
REQ-039 Drive 011,001,011 -> P goes 1 then 0; step on both transitions.
